// File: rtl/decode_sched_pkg.sv
// -----------------------------------------------------------------------------
// decode_sched_pkg
//   Shared definitions for the LZS decode-engine scheduler: FSM state
//   encodings (3-bit, legacy values kept), engine flush length, counter
//   widths and a saturating increment helper.
// -----------------------------------------------------------------------------
package decode_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_CLR  = 3'd2,
    S_RUN  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  localparam int unsigned CLR_CYCLES = 2;   // engine flush cycles
  localparam int unsigned CLR_W      = 1;   // width of flush-cycle counter
  localparam int unsigned WORD_CNT_W = 16;
  localparam int unsigned WDOG_W     = 12;

  function automatic logic [WORD_CNT_W-1:0] sat_inc(input logic [WORD_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/decode_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: first requester at or after ptr_i,
//   wrapping modulo NCH.
// Ports:
//   req_i  [NCH-1:0]  request vector
//   ptr_i  [CW-1:0]   search start index
//   idx_o  [CW-1:0]   chosen index (0 when none)
//   any_o             at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  ptr_i,
  output logic [CW-1:0]  idx_o,
  output logic           any_o
);

  always_comb begin : p_pick
    int unsigned s;
    logic [CW-1:0] k;
    idx_o = '0;
    any_o = 1'b0;
    s     = 0;
    k     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      s = 32'(ptr_i) + i;
      if (s >= NCH) s = s - NCH;
      k = CW'(s);
      if (!any_o && req_i[k]) begin
        any_o = 1'b1;
        idx_o = k;
      end
    end
  end

endmodule

// File: rtl/decode_sched.sv
// -----------------------------------------------------------------------------
// decode_sched
//   Shares one LZS decode engine among NCH source channels. Round-robin
//   selects a requesting channel, flushes the engine for two cycles, muxes
//   that channel's source FIFO to the engine, counts emitted words and acks
//   the channel when the engine signals end-of-stream.
//   Optional watchdog: define DECODE_SCHED_WDOG_EN to abort a job whose
//   engine is silent for WDOG cycles (ch_err pulse instead of ch_ack).
// Ports:
//   clk, rstn                 clock, async active-low reset
//   ch_req/ch_src_empty [NCH] per-channel job request / source FIFO empty
//   ch_src_getn [NCH]         per-channel FIFO read strobe (active-low)
//   ch_ack/ch_err [NCH]       job-complete / watchdog-abort pulses
//   eng_rst, eng_ce           engine sync reset and clock enable
//   eng_src_empty/getn        muxed FIFO empty to / read strobe from engine
//   eng_valid, eng_done       engine word valid / end-of-stream
//   fo_full                   output FIFO full (engine stalls on it)
//   grant_idx [CW]            channel owning the engine
//   busy, word_cnt [16]       not idle / words emitted by current job
// -----------------------------------------------------------------------------
module decode_sched
  import decode_sched_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CW   = 2,
  parameter int unsigned WDOG = 4095
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_src_empty,
  output logic [NCH-1:0]        ch_src_getn,
  output logic [NCH-1:0]        ch_ack,
  output logic [NCH-1:0]        ch_err,
  output logic                  eng_rst,
  output logic                  eng_ce,
  output logic                  eng_src_empty,
  input  logic                  eng_src_getn,
  input  logic                  eng_valid,
  input  logic                  eng_done,
  input  logic                  fo_full,
  output logic [CW-1:0]         grant_idx,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  state_e                state_q, state_d;
  logic [CW-1:0]         grant_q, grant_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CLR_W-1:0]      clr_q, clr_d;
  logic [WORD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  abort_q, abort_d;
  logic                  wd_hit;

  logic [CW-1:0]         arb_idx;
  logic                  arb_any;

  rr_arbiter #(
    .NCH (NCH),
    .CW  (CW)
  ) u_arb (
    .req_i (ch_req),
    .ptr_i (ptr_q),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: if (|ch_req) state_d = S_ARB;
      S_ARB: begin
        // A request withdrawn between IDLE and ARB leaves nothing to grant.
        if (arb_any) begin
          grant_d = arb_idx;
          ptr_d   = (32'(arb_idx) == NCH - 1) ? '0 : arb_idx + 1'b1;
          clr_d   = '0;
          abort_d = 1'b0;
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        cnt_d = '0;
        if (clr_q == CLR_W'(CLR_CYCLES - 1)) state_d = S_RUN;
        else                                 clr_d   = clr_q + 1'b1;
      end
      S_RUN: begin
        if (eng_valid) cnt_d = sat_inc(cnt_q);
        if (eng_done) begin
          state_d = S_FIN;
        end else if (wd_hit) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      clr_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    eng_rst       = 1'b1;
    eng_ce        = 1'b0;
    eng_src_empty = 1'b1;
    ch_src_getn   = '1;
    ch_ack        = '0;
    case (state_q)
      S_CLR: eng_ce = 1'b1;
      S_RUN: begin
        eng_rst              = 1'b0;
        eng_ce               = 1'b1;
        eng_src_empty        = ch_src_empty[grant_q];
        ch_src_getn[grant_q] = eng_src_getn;
      end
      S_FIN: if (!abort_q) ch_ack[grant_q] = 1'b1;
      default: ;
    endcase
  end

`ifdef DECODE_SCHED_WDOG_EN
  logic [WDOG_W-1:0] wd_q, wd_d;

  // Counts only cycles where the engine could progress but does nothing;
  // output back-pressure freezes the count.
  always_comb begin
    wd_d   = wd_q;
    wd_hit = 1'b0;
    if (state_q != S_RUN) begin
      wd_d = '0;
    end else if (eng_valid || !eng_src_getn) begin
      wd_d = '0;
    end else if (!fo_full) begin
      if (wd_q == WDOG_W'(WDOG - 1)) wd_hit = 1'b1;
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  always_comb begin
    ch_err = '0;
    if (state_q == S_FIN && abort_q) ch_err[grant_q] = 1'b1;
  end
`else
  logic              unused_fo_full;
  logic [WDOG_W-1:0] unused_wdog;
  assign wd_hit         = 1'b0;
  assign ch_err         = '0;
  assign unused_fo_full = fo_full;
  assign unused_wdog    = WDOG_W'(WDOG);
`endif

  assign grant_idx = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_sched.sv
`timescale 1ns/1ps
module tb_decode_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  ch_req, ch_src_empty, ch_src_getn, ch_ack, ch_err;
  logic        eng_rst, eng_ce, eng_src_empty, eng_src_getn;
  logic        eng_valid, eng_done, fo_full, busy;
  logic [1:0]  grant_idx;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  decode_sched #(.NCH(4), .CW(2), .WDOG(16)) dut (
    .clk(clk), .rstn(rstn), .ch_req(ch_req), .ch_src_empty(ch_src_empty),
    .ch_src_getn(ch_src_getn), .ch_ack(ch_ack), .ch_err(ch_err),
    .eng_rst(eng_rst), .eng_ce(eng_ce), .eng_src_empty(eng_src_empty),
    .eng_src_getn(eng_src_getn), .eng_valid(eng_valid), .eng_done(eng_done),
    .fo_full(fo_full), .grant_idx(grant_idx), .busy(busy), .word_cnt(word_cnt)
  );

  typedef struct {int ch; int words;} exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ch_req = '0; ch_src_empty = '0; eng_src_getn = 1'b1;
    eng_valid = 1'b0; eng_done = 1'b0; fo_full = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();
  endtask

  // From IDLE with ch_req already driven: walk ARB, CLR, CLR into RUN.
  task automatic start_job(input int ch);
    step();
    total++; if (busy !== 1'b1 || eng_rst !== 1'b1) begin bad++; $display("FAIL arb_state busy=%b rst=%b want 1 1", busy, eng_rst); end
    step();
    total++; if (grant_idx !== 2'(ch)) begin bad++; $display("FAIL grant got=%0d want=%0d", grant_idx, ch); end
    total++; if ({eng_rst, eng_ce} !== 2'b11) begin bad++; $display("FAIL clr1 rst_ce got=%b want 11", {eng_rst, eng_ce}); end
    step();
    total++; if ({eng_rst, eng_ce} !== 2'b11) begin bad++; $display("FAIL clr2 rst_ce got=%b want 11", {eng_rst, eng_ce}); end
    step();
    total++; if ({eng_rst, eng_ce} !== 2'b01) begin bad++; $display("FAIL run_latency rst_ce got=%b want 01", {eng_rst, eng_ce}); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL cnt_clear got=%0d want 0", word_cnt); end
  endtask

  task automatic feed_words(input int n);
    for (int i = 0; i < n; i++) begin
      eng_valid = 1'b1;
      step();
    end
    eng_valid = 1'b0;
  endtask

  // Drives done (optionally merged with a final word), then waits for the ack.
  task automatic finish_job(input int ch, input int words, input bit merge, input logic [3:0] req_after);
    bit   found;
    exp_t e;
    eng_done  = 1'b1;
    eng_valid = merge;
    sb.push_back('{ch: ch, words: words});
    step();
    eng_done  = 1'b0;
    eng_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (ch_ack !== 4'b0) found = 1'b1;
      else step();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL ack_timeout ch_ack=%b want pulse for ch%0d", ch_ack, ch);
    end else if (sb.size() == 0) begin
      bad++; $display("FAIL sb_empty ch_ack=%b with no expected job", ch_ack);
    end else begin
      e = sb.pop_front();
      if (ch_ack !== 4'(1 << e.ch)) begin bad++; $display("FAIL ack_vec got=%b want=%b", ch_ack, 4'(1 << e.ch)); end
      total++; if (word_cnt !== 16'(e.words)) begin bad++; $display("FAIL word_cnt got=%0d want=%0d", word_cnt, e.words); end
      total++; if ({eng_rst, eng_ce, ch_err} !== {2'b10, 4'b0}) begin bad++; $display("FAIL fin_outs rst_ce_err got=%b want 100000", {eng_rst, eng_ce, ch_err}); end
    end
    ch_req = req_after;
    step();
    total++; if (ch_ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_fin ack=%b busy=%b want 0000 0", ch_ack, busy); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    total++; if (ch_src_getn !== 4'hF || ch_ack !== 4'h0 || ch_err !== 4'h0) begin bad++; $display("FAIL reset_ch getn=%b ack=%b err=%b want 1111 0000 0000", ch_src_getn, ch_ack, ch_err); end
    total++; if ({eng_rst, eng_ce, eng_src_empty, busy} !== 4'b1010) begin bad++; $display("FAIL reset_eng rst_ce_empty_busy=%b want 1010", {eng_rst, eng_ce, eng_src_empty, busy}); end
    total++; if (grant_idx !== 2'd0 || word_cnt !== 16'd0) begin bad++; $display("FAIL reset_regs grant=%0d cnt=%0d want 0 0", grant_idx, word_cnt); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single_job();
    apply_reset();
    ch_req = 4'b0100;
    start_job(2);
    feed_words(10);
    finish_job(2, 10, 1'b0, 4'b0);
  endtask

  task automatic test_round_robin();
    int order [7];
    order = '{0, 1, 2, 3, 0, 3, 0};
    apply_reset();
    ch_req = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      start_job(order[i]);
      feed_words(i + 1);
      finish_job(order[i], i + 1, 1'b0, (i == 6) ? 4'b0000 : ((i >= 4) ? 4'b1001 : 4'b1111));
    end
  endtask

  task automatic test_getn_mux();
    apply_reset();
    ch_req = 4'b0010;
    start_job(1);
    for (int i = 0; i < 8; i++) begin
      eng_src_getn = i[0];
      ch_src_empty = 4'(i * 5 + 3);
      #1;
      total++; if (ch_src_getn !== ((i % 2 == 1) ? 4'b1111 : 4'b1101)) begin bad++; $display("FAIL getn_mux i=%0d got=%b want=%b", i, ch_src_getn, (i % 2 == 1) ? 4'b1111 : 4'b1101); end
      total++; if (eng_src_empty !== ch_src_empty[1]) begin bad++; $display("FAIL empty_mux i=%0d got=%b want=%b", i, eng_src_empty, ch_src_empty[1]); end
      step();
    end
    eng_src_getn = 1'b1;
    ch_src_empty = 4'b0000;
    finish_job(1, 0, 1'b0, 4'b0);
    total++; if (ch_src_getn !== 4'hF || eng_src_empty !== 1'b1) begin bad++; $display("FAIL idle_mux getn=%b empty=%b want 1111 1", ch_src_getn, eng_src_empty); end
  endtask

  task automatic test_valid_done_same();
    apply_reset();
    ch_req = 4'b0001;
    start_job(0);
    feed_words(5);
    finish_job(0, 6, 1'b1, 4'b0);
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    ch_req = 4'b0100;
    start_job(2);
    feed_words(3);
    ch_req = 4'b1100;
    rstn = 1'b0;
    #1;
    total++; if ({eng_rst, eng_ce, busy, grant_idx} !== 5'b10000 || word_cnt !== 16'd0 || ch_src_getn !== 4'hF) begin bad++; $display("FAIL async_reset rst_ce_busy_grant=%b cnt=%0d getn=%b want 10000 0 1111", {eng_rst, eng_ce, busy, grant_idx}, word_cnt, ch_src_getn); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (ch_ack !== 4'b0 || ch_err !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_hold cyc=%0d ack=%b err=%b busy=%b want 0000 0000 0", i, ch_ack, ch_err, busy); end
    end
    rstn = 1'b1;
    start_job(2);
    finish_job(2, 0, 1'b0, 4'b0);
  endtask

`ifdef DECODE_SCHED_WDOG_EN
  task automatic test_watchdog();
    int n;
    bit found;
    apply_reset();
    ch_req = 4'b0001;
    start_job(0);
    n = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n++;
      if (ch_err !== 4'b0) found = 1'b1;
    end
    total++; if (!found || n != 16) begin bad++; $display("FAIL wdog_delay found=%0d cycles=%0d want 1 16", found, n); end
    total++; if (ch_err !== 4'b0001 || ch_ack !== 4'b0) begin bad++; $display("FAIL wdog_pulse err=%b ack=%b want 0001 0000", ch_err, ack_str(ch_ack)); end
    step();
    total++; if (ch_err !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL wdog_after err=%b busy=%b want 0000 0", ch_err, busy); end
    start_job(0);
    fo_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      total++; if (ch_err !== 4'b0) begin bad++; $display("FAIL wdog_fofull cyc=%0d err=%b want 0000", i, ch_err); end
    end
    total++; if (eng_ce !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL fofull_run ce=%b busy=%b want 1 1", eng_ce, busy); end
    fo_full = 1'b0;
    finish_job(0, 0, 1'b0, 4'b0);
  endtask

  function automatic logic [3:0] ack_str(input logic [3:0] v);
    return v;
  endfunction
`else
  task automatic test_watchdog();
    apply_reset();
    ch_req = 4'b0001;
    start_job(0);
    fo_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) fo_full = 1'b0;
      step();
      total++; if (ch_err !== 4'b0) begin bad++; $display("FAIL no_wdog_err cyc=%0d err=%b want 0000", i, ch_err); end
    end
    total++; if (busy !== 1'b1 || eng_ce !== 1'b1) begin bad++; $display("FAIL no_wdog_run busy=%b ce=%b want 1 1", busy, eng_ce); end
    finish_job(0, 0, 1'b0, 4'b0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_getn_mux();
    test_valid_done_same();
    test_reset_mid_run();
    test_watchdog();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d pending want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
